// File: rtl/reservation_station_mp.sv
// reservation_station_mp: out-of-order reservation station issuing the oldest ready op
// through a valid/ready output register. Optional build macro: RS_WAKEUP_BYPASS_EN.
module reservation_station_mp #(
    parameter int RS_DEPTH  = 8,
    parameter int ROB_W     = 4,
    parameter int DATA_W    = 32,
    parameter int OP_W      = 6,
    parameter int CDB_PORTS = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [OP_W-1:0]               in_op,
    input  logic [ROB_W-1:0]              in_Qj,
    input  logic [ROB_W-1:0]              in_Qk,
    input  logic [DATA_W-1:0]             in_Vj,
    input  logic [DATA_W-1:0]             in_Vk,
    input  logic [DATA_W-1:0]             in_pc,
    input  logic [DATA_W-1:0]             in_imm,
    input  logic [ROB_W-1:0]              in_rd_rob,
    input  logic                          in_has_rd_dest,
    input  logic [CDB_PORTS-1:0]          cdb_valid,
    input  logic [CDB_PORTS*ROB_W-1:0]    cdb_tag,
    input  logic [CDB_PORTS*DATA_W-1:0]   cdb_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OP_W-1:0]               out_op,
    output logic [DATA_W-1:0]             out_Vj,
    output logic [DATA_W-1:0]             out_Vk,
    output logic [DATA_W-1:0]             out_pc,
    output logic [DATA_W-1:0]             out_imm,
    output logic [ROB_W-1:0]              out_rob_tag,
    output logic [$clog2(RS_DEPTH+1)-1:0] free_count
);
    localparam int CNT_W  = $clog2(RS_DEPTH + 1);
    localparam int RANK_W = $clog2(RS_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RS_DEPTH);

    // Lowest-numbered bus carrying a nonzero matching tag supplies the value.
    function automatic logic cdb_lookup(
        input  logic [ROB_W-1:0]            tag,
        input  logic [CDB_PORTS-1:0]        valid,
        input  logic [CDB_PORTS*ROB_W-1:0]  tags,
        input  logic [CDB_PORTS*DATA_W-1:0] data,
        output logic [DATA_W-1:0]           value
    );
        logic hit;
        hit   = 1'b0;
        value = '0;
        for (int k = 0; k < CDB_PORTS; k++) begin
            if (!hit && valid[k] && (tag != '0) && (tags[k*ROB_W +: ROB_W] == tag)) begin
                hit   = 1'b1;
                value = data[k*DATA_W +: DATA_W];
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

    logic [RS_DEPTH-1:0] busy_q, busy_d;
    logic [RANK_W-1:0]   age_q [RS_DEPTH];
    logic [RANK_W-1:0]   age_d [RS_DEPTH];
    logic [OP_W-1:0]     op_q  [RS_DEPTH];
    logic [OP_W-1:0]     op_d  [RS_DEPTH];
    logic [ROB_W-1:0]    qj_q  [RS_DEPTH];
    logic [ROB_W-1:0]    qj_d  [RS_DEPTH];
    logic [ROB_W-1:0]    qk_q  [RS_DEPTH];
    logic [ROB_W-1:0]    qk_d  [RS_DEPTH];
    logic [ROB_W-1:0]    rd_q  [RS_DEPTH];
    logic [ROB_W-1:0]    rd_d  [RS_DEPTH];
    logic [DATA_W-1:0]   vj_q  [RS_DEPTH];
    logic [DATA_W-1:0]   vj_d  [RS_DEPTH];
    logic [DATA_W-1:0]   vk_q  [RS_DEPTH];
    logic [DATA_W-1:0]   vk_d  [RS_DEPTH];
    logic [DATA_W-1:0]   pc_q  [RS_DEPTH];
    logic [DATA_W-1:0]   pc_d  [RS_DEPTH];
    logic [DATA_W-1:0]   imm_q [RS_DEPTH];
    logic [DATA_W-1:0]   imm_d [RS_DEPTH];

    logic [ROB_W-1:0]    qj_w  [RS_DEPTH];
    logic [ROB_W-1:0]    qk_w  [RS_DEPTH];
    logic [DATA_W-1:0]   vj_w  [RS_DEPTH];
    logic [DATA_W-1:0]   vk_w  [RS_DEPTH];
    logic [DATA_W-1:0]   cj_val_s [RS_DEPTH];
    logic [DATA_W-1:0]   ck_val_s [RS_DEPTH];
    logic [RS_DEPTH-1:0] hit_j_s, hit_k_s, ready_s;

    logic                din_hit_j_s, din_hit_k_s;
    logic [DATA_W-1:0]   din_vj_s, din_vk_s;

    logic [CNT_W-1:0]    count_s;
    logic                sel_found_s, free_found_s;
    logic [RANK_W-1:0]   sel_idx_s, sel_rank_s, free_idx_s;
    logic                issue_load_s, issue_fire_s, disp_fire_s;

    logic                out_valid_q, out_valid_d;
    logic [OP_W-1:0]     out_op_q, out_op_d;
    logic [DATA_W-1:0]   out_vj_q, out_vj_d, out_vk_q, out_vk_d;
    logic [DATA_W-1:0]   out_pc_q, out_pc_d, out_imm_q, out_imm_d;
    logic [ROB_W-1:0]    out_rob_q, out_rob_d;

    // CDB snoop: post-wake-up operand view of every entry plus dispatch-time capture.
    always_comb begin
        hit_j_s = '0;
        hit_k_s = '0;
        ready_s = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            hit_j_s[i] = cdb_lookup(qj_q[i], cdb_valid, cdb_tag, cdb_data, cj_val_s[i]);
            hit_k_s[i] = cdb_lookup(qk_q[i], cdb_valid, cdb_tag, cdb_data, ck_val_s[i]);
            qj_w[i]    = hit_j_s[i] ? '0 : qj_q[i];
            qk_w[i]    = hit_k_s[i] ? '0 : qk_q[i];
            vj_w[i]    = hit_j_s[i] ? cj_val_s[i] : vj_q[i];
            vk_w[i]    = hit_k_s[i] ? ck_val_s[i] : vk_q[i];
`ifdef RS_WAKEUP_BYPASS_EN
            ready_s[i] = busy_q[i] && (qj_w[i] == '0) && (qk_w[i] == '0);
`else
            ready_s[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
`endif
        end
        din_hit_j_s = cdb_lookup(in_Qj, cdb_valid, cdb_tag, cdb_data, din_vj_s);
        din_hit_k_s = cdb_lookup(in_Qk, cdb_valid, cdb_tag, cdb_data, din_vk_s);
    end

    // Occupancy count, oldest-ready select and lowest free slot.
    always_comb begin
        count_s      = '0;
        sel_found_s  = 1'b0;
        sel_idx_s    = '0;
        sel_rank_s   = '0;
        free_found_s = 1'b0;
        free_idx_s   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            count_s = count_s + CNT_W'(busy_q[i]);
            if (ready_s[i] && (!sel_found_s || (age_q[i] < sel_rank_s))) begin
                sel_found_s = 1'b1;
                sel_idx_s   = RANK_W'(i);
                sel_rank_s  = age_q[i];
            end else begin
                sel_found_s = sel_found_s;
            end
            if (!busy_q[i] && !free_found_s) begin
                free_found_s = 1'b1;
                free_idx_s   = RANK_W'(i);
            end else begin
                free_found_s = free_found_s;
            end
        end
    end

    assign in_ready     = ena & (count_s < DEPTH_C) & ~flush;
    assign free_count   = DEPTH_C - count_s;
    assign issue_load_s = ~out_valid_q | out_ready;
    assign issue_fire_s = ena & ~flush & issue_load_s & sel_found_s;
    assign disp_fire_s  = in_valid & in_ready & free_found_s;

    // Next state: flush, wake-up, issue with rank compaction, then dispatch.
    always_comb begin
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        out_op_d    = out_op_q;
        out_vj_d    = out_vj_q;
        out_vk_d    = out_vk_q;
        out_pc_d    = out_pc_q;
        out_imm_d   = out_imm_q;
        out_rob_d   = out_rob_q;
        for (int i = 0; i < RS_DEPTH; i++) begin
            age_d[i] = age_q[i];
            op_d[i]  = op_q[i];
            qj_d[i]  = qj_q[i];
            qk_d[i]  = qk_q[i];
            vj_d[i]  = vj_q[i];
            vk_d[i]  = vk_q[i];
            pc_d[i]  = pc_q[i];
            imm_d[i] = imm_q[i];
            rd_d[i]  = rd_q[i];
        end
        if (ena && flush) begin
            busy_d      = '0;
            out_valid_d = 1'b0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                age_d[i] = '0;
            end
        end else if (ena) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                qj_d[i] = qj_w[i];
                qk_d[i] = qk_w[i];
                vj_d[i] = vj_w[i];
                vk_d[i] = vk_w[i];
            end
            if (issue_fire_s) begin
                out_valid_d       = 1'b1;
                out_op_d          = op_q[sel_idx_s];
                out_vj_d          = vj_w[sel_idx_s];
                out_vk_d          = vk_w[sel_idx_s];
                out_pc_d          = pc_q[sel_idx_s];
                out_imm_d         = imm_q[sel_idx_s];
                out_rob_d         = rd_q[sel_idx_s];
                busy_d[sel_idx_s] = 1'b0;
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (busy_q[i] && (age_q[i] > sel_rank_s)) begin
                        age_d[i] = age_q[i] - RANK_W'(1);
                    end else begin
                        age_d[i] = age_q[i];
                    end
                end
            end else if (issue_load_s) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
            if (disp_fire_s) begin
                busy_d[free_idx_s] = 1'b1;
                // Rank counts survivors only, so a same-cycle issue shifts the newcomer down.
                age_d[free_idx_s]  = RANK_W'(count_s - CNT_W'(issue_fire_s));
                op_d[free_idx_s]   = in_op;
                pc_d[free_idx_s]   = in_pc;
                imm_d[free_idx_s]  = in_imm;
                rd_d[free_idx_s]   = in_has_rd_dest ? in_rd_rob : '0;
                qj_d[free_idx_s]   = din_hit_j_s ? '0 : in_Qj;
                qk_d[free_idx_s]   = din_hit_k_s ? '0 : in_Qk;
                vj_d[free_idx_s]   = din_hit_j_s ? din_vj_s : in_Vj;
                vk_d[free_idx_s]   = din_hit_k_s ? din_vk_s : in_Vk;
            end else begin
                busy_d = busy_d;
            end
        end else begin
            busy_d = busy_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_vj_q    <= '0;
            out_vk_q    <= '0;
            out_pc_q    <= '0;
            out_imm_q   <= '0;
            out_rob_q   <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                age_q[i] <= '0;
                op_q[i]  <= '0;
                qj_q[i]  <= '0;
                qk_q[i]  <= '0;
                vj_q[i]  <= '0;
                vk_q[i]  <= '0;
                pc_q[i]  <= '0;
                imm_q[i] <= '0;
                rd_q[i]  <= '0;
            end
        end else begin
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_vj_q    <= out_vj_d;
            out_vk_q    <= out_vk_d;
            out_pc_q    <= out_pc_d;
            out_imm_q   <= out_imm_d;
            out_rob_q   <= out_rob_d;
            for (int i = 0; i < RS_DEPTH; i++) begin
                age_q[i] <= age_d[i];
                op_q[i]  <= op_d[i];
                qj_q[i]  <= qj_d[i];
                qk_q[i]  <= qk_d[i];
                vj_q[i]  <= vj_d[i];
                vk_q[i]  <= vk_d[i];
                pc_q[i]  <= pc_d[i];
                imm_q[i] <= imm_d[i];
                rd_q[i]  <= rd_d[i];
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_op      = out_op_q;
    assign out_Vj      = out_vj_q;
    assign out_Vk      = out_vk_q;
    assign out_pc      = out_pc_q;
    assign out_imm     = out_imm_q;
    assign out_rob_tag = out_rob_q;

endmodule
